md_seq_6801: RTL and testbench
==============================

Name: md_seq_6801

Overview:
- Parametrised multi-byte memory-data (MD) register with a built-in byte-serial fetch/store sequencer.
- Successor to the fixed 16-bit MD latch in the 6801 memory controller.
- Generalised operand width (BYTES); fetches N bytes big-endian from the 8-bit data bus under a valid handshake.
- Emits N bytes MSB-first with a valid/ready handshake, so the control FSM issues one command per operand instead of one per byte.

Parameters:
BYTES, 2, operand width in bytes (1..4); W = 8*BYTES.
LW, $clog2(BYTES+1), width of the len port.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
hold  in  1  global stall; freezes all registered state
cmd  in  3  000 NOP, 001 LOAD, 010 FETCH, 011 STORE, 100 SHL, 101 SHR, 110 CLEAR, 111 ABORT
len  in  LW  byte count for FETCH/STORE
data_in  in  8  memory read byte
data_valid  in  1  data_in holds a valid byte this cycle
alu_in  in  W  ALU result for LOAD
md  out  W  memory-data register
data_out  out  8  byte being stored
data_out_valid  out  1  data_out valid
data_out_ready  in  1  memory accepts data_out
busy  out  1  sequencer in FETCH or STORE
done  out  1  one-cycle completion pulse
shift_out  out  1  bit shifted out by the last SHL/SHR

Behaviour:
- Reset (sync, wins over hold and cmd) sets:
  - md=0, state=IDLE, cnt=0, done=0, shift_out=0.
  - busy=0 and data_out_valid=0 in the following cycle.
- hold=1:
  - md, state, cnt, done and shift_out keep their values.
  - cmd, data_valid and data_out_ready are ignored.
  - data_out_valid is forced 0.
  - Consumers qualify done with !hold.
- States: IDLE, FETCH, STORE. busy = (state != IDLE), registered.
- IDLE commands, each applied at the next edge:
  - LOAD: md<=alu_in.
  - CLEAR: md<=0.
  - SHL: md<={md[W-2:0],0}, shift_out<=md[W-1].
  - SHR: md<={0,md[W-1:1]}, shift_out<=md[0].
  - NOP and ABORT: no effect.
- len handling:
  - Effective count n = min(len, BYTES).
  - n=0 on FETCH/STORE: no transfer, no state change, done=1 next cycle.
- FETCH, cmd in cycle t:
  - At t+1: md<=0, cnt<=n, state=FETCH.
  - Each edge with data_valid=1 (state FETCH, !hold): md<={md[W-9:0],data_in}, cnt<=cnt-1.
  - After the edge where the n-th byte is accepted: state=IDLE, done=1 for one cycle.
  - Result is right-aligned: the first byte lands in lane n-1, the last in lane 0, upper lanes stay 0.
- STORE, cmd in cycle t:
  - At t+1: cnt<=n, state=STORE.
  - data_out = md byte lane (cnt-1), combinational.
  - data_out_valid = (state==STORE) & !hold.
  - On valid & ready: cnt<=cnt-1.
  - After the edge where the last byte is accepted: state=IDLE, done=1 for one cycle.
  - md is never modified by STORE.
- While busy:
  - Every cmd except ABORT and CLEAR is ignored.
  - ABORT: state<=IDLE, cnt<=0, md keeps any partial value, no done.
  - CLEAR while busy: same as ABORT plus md<=0.
- done is 0 in every other cycle. A new cmd may be issued in the cycle done=1 (state is already IDLE).
- Throughput: one byte per cycle when data_valid / data_out_ready are held high.
  - BYTES=2 fetch: cmd at t, bytes at t+1 and t+2, done at t+3.

Test Plan:
- BYTES=2, reset, then FETCH len=2 with bytes 0x12, 0x34 on consecutive cycles -> md=0x1234, done high exactly one cycle (t+3), busy low at t+3.
- BYTES=4, FETCH len=3 with bytes 0xAB, 0xCD, 0xEF and data_valid gapped by 2 idle cycles each -> md=0x00ABCDEF, one done pulse after the third byte only.
- BYTES=2, LOAD alu_in=0xBEEF, STORE len=2 with data_out_ready low 3 cycles then high -> data_out=0xBE held stable while stalled, then 0xEF; md still 0xBEEF; done once.
- BYTES=2, md=0x8001: SHL -> md=0x0002, shift_out=1; SHR -> md=0x0001, shift_out=0; hold=1 for 4 cycles during a FETCH -> no state/md change, data_out_valid=0.
- FETCH len=2, ABORT after first byte 0x55 -> state IDLE, md=0x0055, no done; then reset asserted mid-STORE -> md=0, busy=0, data_out_valid=0 next cycle.
- FETCH len=0 -> done next cycle, md unchanged. BYTES=2 FETCH len=3 -> clamped to 2 bytes.

Source files
------------

// File: rtl/md_seq_6801.sv
// Multi-byte memory-data register with a byte-serial fetch/store sequencer.
// Fetches/emits up to BYTES bytes big-endian over an 8-bit bus with valid/ready handshakes.
module md_seq_6801 #(
    parameter int unsigned BYTES = 2,
    parameter int unsigned LW    = $clog2(BYTES + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               hold_i,
    input  logic [2:0]         cmd_i,
    input  logic [LW-1:0]      len_i,
    input  logic [7:0]         data_in_i,
    input  logic               data_valid_i,
    input  logic [8*BYTES-1:0] alu_in_i,
    output logic [8*BYTES-1:0] md_o,
    output logic [7:0]         data_out_o,
    output logic               data_out_valid_o,
    input  logic               data_out_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               shift_out_o
);
    localparam int unsigned W = 8 * BYTES;

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_LOAD  = 3'b001;
    localparam logic [2:0] CMD_FETCH = 3'b010;
    localparam logic [2:0] CMD_STORE = 3'b011;
    localparam logic [2:0] CMD_SHL   = 3'b100;
    localparam logic [2:0] CMD_SHR   = 3'b101;
    localparam logic [2:0] CMD_CLEAR = 3'b110;
    localparam logic [2:0] CMD_ABORT = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;

    logic [W-1:0]  md_q, md_d;
    logic [1:0]    state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          shift_q, shift_d;
    logic [LW-1:0] n_c;
    logic [LW-1:0] lane_c;

    // Byte count clamped to the operand width
    assign n_c    = (32'(len_i) > BYTES) ? LW'(BYTES) : len_i;
    assign lane_c = (cnt_q == '0) ? '0 : cnt_q - LW'(1);

    assign md_o             = md_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = done_q;
    assign shift_out_o      = shift_q;
    assign data_out_o       = 8'(md_q >> {lane_c, 3'b000});
    assign data_out_valid_o = (state_q == ST_STORE) && !hold_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            md_q    <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            md_q    <= md_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        md_d    = md_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        shift_d = shift_q;
        if (!hold_i) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    case (cmd_i)
                        CMD_LOAD:  md_d = alu_in_i;
                        CMD_CLEAR: md_d = '0;
                        CMD_SHL: begin
                            md_d    = {md_q[W-2:0], 1'b0};
                            shift_d = md_q[W-1];
                        end
                        CMD_SHR: begin
                            md_d    = {1'b0, md_q[W-1:1]};
                            shift_d = md_q[0];
                        end
                        CMD_FETCH: begin
                            if (n_c == '0) begin
                                done_d = 1'b1;
                            end else begin
                                md_d    = '0;
                                cnt_d   = n_c;
                                state_d = ST_FETCH;
                            end
                        end
                        CMD_STORE: begin
                            if (n_c == '0) begin
                                done_d = 1'b1;
                            end else begin
                                cnt_d   = n_c;
                                state_d = ST_STORE;
                            end
                        end
                        CMD_NOP, CMD_ABORT: ;
                        default: ;
                    endcase
                end
                ST_FETCH, ST_STORE: begin
                    // Abort/clear take priority over a byte transfer in the same cycle
                    if (cmd_i == CMD_ABORT || cmd_i == CMD_CLEAR) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (cmd_i == CMD_CLEAR) md_d = '0;
                    end else if ((state_q == ST_FETCH && data_valid_i) ||
                                 (state_q == ST_STORE && data_out_ready_i)) begin
                        if (state_q == ST_FETCH) md_d = (md_q << 8) | W'(data_in_i);
                        cnt_d = cnt_q - LW'(1);
                        if (cnt_q == LW'(1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_seq_6801.sv
// Self-checking bench for md_seq_6801 (BYTES=2): directed scenarios plus random
// commands compared every cycle against a queue-based behavioural model.
module tb_md_seq_6801;
    localparam int unsigned BYTES = 2;
    localparam int unsigned LW    = 2;

    logic          clk = 1'b0;
    logic          reset, hold, dv, rdy;
    logic [2:0]    cmd;
    logic [LW-1:0] len;
    logic [7:0]    din;
    logic [15:0]   alu;
    logic [15:0]   md;
    logic [7:0]    dout;
    logic          dov, busy, done, shout;

    int n_cmp = 0;
    int n_err = 0;

    md_seq_6801 #(.BYTES(BYTES), .LW(LW)) dut (
        .clk_i(clk), .reset_i(reset), .hold_i(hold), .cmd_i(cmd), .len_i(len),
        .data_in_i(din), .data_valid_i(dv), .alu_in_i(alu), .md_o(md),
        .data_out_o(dout), .data_out_valid_o(dov), .data_out_ready_i(rdy),
        .busy_o(busy), .done_o(done), .shift_out_o(shout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 collecting bytes, 2 emitting a byte queue
    int         m_mode;
    int         m_need;
    logic [15:0] m_md;
    bit         m_done, m_shift;
    byte unsigned m_q[$];

    task automatic model_reset();
        m_mode = 0; m_need = 0; m_md = 16'h0; m_done = 0; m_shift = 0; m_q.delete();
    endtask

    task automatic model_edge();
        int n;
        if (reset) begin
            model_reset();
            return;
        end
        if (hold) return;
        m_done = 0;
        n = (int'(len) > BYTES) ? BYTES : int'(len);
        if (m_mode == 0) begin
            case (cmd)
                3'd1: m_md = alu;
                3'd6: m_md = 16'h0;
                3'd4: begin m_shift = m_md[15]; m_md = m_md * 2; end
                3'd5: begin m_shift = m_md[0];  m_md = m_md / 2; end
                3'd2: if (n == 0) m_done = 1;
                      else begin m_md = 0; m_need = n; m_mode = 1; end
                3'd3: if (n == 0) m_done = 1;
                      else begin
                          for (int i = n - 1; i >= 0; i--) m_q.push_back(byte'(m_md / (16'h1 << (8*i))));
                          m_mode = 2;
                      end
                default: ;
            endcase
        end else if (cmd == 3'd7 || cmd == 3'd6) begin
            if (cmd == 3'd6) m_md = 16'h0;
            m_mode = 0; m_need = 0; m_q.delete();
        end else if (m_mode == 1 && dv) begin
            m_md = m_md * 256 + din;
            m_need--;
            if (m_need == 0) begin m_mode = 0; m_done = 1; end
        end else if (m_mode == 2 && rdy) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin m_mode = 0; m_done = 1; end
        end
    endtask

    // One clock: check combinational outputs, clock, update model, check registered outputs
    task automatic cycle();
        #1;
        check("dov", dov, (m_mode == 2) && !hold);
        if (m_mode == 2 && !hold) check("dout", dout, m_q[0]);
        @(posedge clk);
        model_edge();
        #1;
        check("md", md, m_md);
        check("busy", busy, m_mode != 0);
        check("done", done, m_done);
        check("shift", shout, m_shift);
    endtask

    task automatic drive(input logic [2:0] c, input logic [LW-1:0] l, input logic v,
                         input logic [7:0] d, input logic r, input logic h);
        cmd = c; len = l; dv = v; din = d; rdy = r; hold = h;
        cycle();
    endtask

    initial begin
        model_reset();
        reset = 1; hold = 0; cmd = 0; len = 0; dv = 0; din = 0; rdy = 0; alu = 0;
        cycle(); cycle();
        check("rst_md", md, 16'h0);
        check("rst_busy", busy, 1'b0);
        reset = 0;

        // Back-to-back fetch of 0x12, 0x34
        drive(3'd2, 2, 0, 8'h00, 0, 0);
        drive(3'd0, 0, 1, 8'h12, 0, 0);
        check("fetch_busy_mid", busy, 1'b1);
        drive(3'd0, 0, 1, 8'h34, 0, 0);
        check("fetch_md", md, 16'h1234);
        check("fetch_done", done, 1'b1);
        check("fetch_busy", busy, 1'b0);
        drive(3'd0, 0, 0, 8'h00, 0, 0);
        check("fetch_done_once", done, 1'b0);

        // Store with ready stalled three cycles
        alu = 16'hBEEF;
        drive(3'd1, 0, 0, 0, 0, 0);
        drive(3'd3, 2, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, 0, 0, 0, 0, 0);
            check("store_stall_byte", dout, 8'hBE);
        end
        drive(3'd0, 0, 0, 0, 1, 0);
        check("store_second_byte", dout, 8'hEF);
        drive(3'd0, 0, 0, 0, 1, 0);
        check("store_md_kept", md, 16'hBEEF);
        check("store_done", done, 1'b1);

        // Shifts
        alu = 16'h8001;
        drive(3'd1, 0, 0, 0, 0, 0);
        drive(3'd4, 0, 0, 0, 0, 0);
        check("shl_md", md, 16'h0002);
        check("shl_out", shout, 1'b1);
        drive(3'd5, 0, 0, 0, 0, 0);
        check("shr_md", md, 16'h0001);
        check("shr_out", shout, 1'b0);

        // Hold during a fetch freezes everything
        drive(3'd2, 2, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(3'd7, 0, 1, 8'hAA, 1, 1);
        check("hold_busy", busy, 1'b1);
        check("hold_md", md, 16'h0000);
        drive(3'd0, 0, 1, 8'h55, 0, 0);
        drive(3'd7, 0, 0, 0, 0, 0);
        check("abort_md", md, 16'h0055);
        check("abort_busy", busy, 1'b0);
        check("abort_nodone", done, 1'b0);

        // Reset in the middle of a store
        drive(3'd3, 2, 0, 0, 0, 0);
        drive(3'd0, 0, 0, 0, 1, 0);
        reset = 1;
        drive(3'd0, 0, 0, 0, 1, 0);
        reset = 0;
        check("rst_mid_md", md, 16'h0);
        check("rst_mid_busy", busy, 1'b0);
        #1 check("rst_mid_dov", dov, 1'b0);

        // Zero-length and over-length counts
        alu = 16'h1357;
        drive(3'd1, 0, 0, 0, 0, 0);
        drive(3'd2, 0, 0, 0, 0, 0);
        check("len0_done", done, 1'b1);
        check("len0_md", md, 16'h1357);
        drive(3'd2, 3, 0, 0, 0, 0);
        drive(3'd0, 0, 1, 8'hA1, 0, 0);
        drive(3'd0, 0, 1, 8'hB2, 0, 0);
        check("clamp_md", md, 16'hA1B2);
        check("clamp_done", done, 1'b1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            alu   = 16'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            cmd   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
            if (m_mode != 0 && cmd >= 3'd6 && $urandom_range(0, 3) != 0) cmd = 3'd0;
            len   = LW'($urandom);
            dv    = 1'($urandom);
            din   = 8'($urandom);
            rdy   = 1'($urandom);
            hold  = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
